// File: rtl/axis_packetiser_pkg.sv
// -----------------------------------------------------------------------------
// axis_packetiser_pkg
// Shared types and helpers for the AXIS packetiser and its output slice.
//   close_reason_e : why a held beat was (or will be) emitted with tlast set
//   cnt_width()    : bit width of a counter that must hold 0..max_val
// -----------------------------------------------------------------------------
package axis_packetiser_pkg;

    typedef enum logic [1:0] {
        CLOSE_NONE    = 2'd0,
        CLOSE_TLAST   = 2'd1,
        CLOSE_MAXLEN  = 2'd2,
        CLOSE_TIMEOUT = 2'd3
    } close_reason_e;

    // Width of a counter that must represent every value from 0 to max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// -----------------------------------------------------------------------------
// axis_out_reg
// Registered AXIS output slice. Holds one beat (valid, payload, last) and keeps
// it stable until the downstream consumer takes it.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   load_i          capture payload_i/last_i (caller only asserts when free_o)
//   payload_i       beat payload to capture
//   last_i          end-of-packet flag to capture
//   ready_i         downstream ready
//   free_o          slice can accept a new beat this cycle
//   valid_o         registered valid
//   last_o          registered last
//   payload_o       registered payload
// -----------------------------------------------------------------------------
module axis_out_reg
    import axis_packetiser_pkg::*;
#(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load_i,
    input  logic [PAYLOAD_W-1:0] payload_i,
    input  logic                 last_i,
    input  logic                 ready_i,
    output logic                 free_o,
    output logic                 valid_o,
    output logic                 last_o,
    output logic [PAYLOAD_W-1:0] payload_o
);

    logic                 valid_q;
    logic                 last_q;
    logic [PAYLOAD_W-1:0] payload_q;

    assign free_o    = !valid_q || ready_i;
    assign valid_o   = valid_q;
    assign last_o    = last_q;
    assign payload_o = payload_q;

    // Output register: load a new beat, retire a consumed one, or hold while stalled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            payload_q <= {PAYLOAD_W{1'b0}};
        end else if (load_i) begin
            valid_q   <= 1'b1;
            last_q    <= last_i;
            payload_q <= payload_i;
        end else if (ready_i) begin
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            valid_q   <= valid_q;
            last_q    <= last_q;
        end
    end

endmodule

// File: rtl/axis_packetiser.sv
// -----------------------------------------------------------------------------
// axis_packetiser
// Framing stage in front of an AXIS FIFO. One beat is held back in H so tlast
// can be applied after the fact; a packet closes on upstream tlast, on MAX_LEN
// beats, or after TIMEOUT idle cycles with a beat held.
// Optional feature macro: AXIS_PACKETISER_TUSER_EN adds axis_o_tuser, set on a
// last beat that was forced out by the timeout.
// Ports:
//   clk, n_reset          clock, asynchronous active-low reset
//   axis_i_*              upstream stream (tready, tvalid, tlast, tdata)
//   axis_o_*              registered downstream stream (tready from FIFO !full)
//   axis_o_tuser          timeout-closed flag (only with the macro defined)
// -----------------------------------------------------------------------------
module axis_packetiser
    import axis_packetiser_pkg::*;
#(
    parameter int AXIS_BYTES = 1,
    parameter int MAX_LEN    = 256,
    parameter int TIMEOUT    = 1024
) (
    input  logic                    clk,
    input  logic                    n_reset,
    output logic                    axis_i_tready,
    input  logic                    axis_i_tvalid,
    input  logic                    axis_i_tlast,
    input  logic [AXIS_BYTES*8-1:0] axis_i_tdata,
    input  logic                    axis_o_tready,
    output logic                    axis_o_tvalid,
    output logic                    axis_o_tlast,
`ifdef AXIS_PACKETISER_TUSER_EN
    output logic                    axis_o_tuser,
`endif
    output logic [AXIS_BYTES*8-1:0] axis_o_tdata
);

    localparam int DATA_W = AXIS_BYTES * 8;
    localparam int BEAT_W = cnt_width(MAX_LEN);
    localparam int IDLE_W = cnt_width(TIMEOUT);
`ifdef AXIS_PACKETISER_TUSER_EN
    localparam int PAYLOAD_W = DATA_W + 1;
`else
    localparam int PAYLOAD_W = DATA_W;
`endif
    localparam logic [BEAT_W-1:0] MAX_LEN_C   = BEAT_W'(MAX_LEN);
    localparam logic [IDLE_W-1:0] IDLE_LAST_C = IDLE_W'(TIMEOUT - 1);

    // Hold register H and packet counters
    logic               h_valid_q,  h_valid_d;
    logic [DATA_W-1:0]  h_data_q,   h_data_d;
    close_reason_e      h_reason_q, h_reason_d;
    logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;

    logic               h_close_s;
    logic               o_free_s;
    logic               accept_s;
    logic               idle_hit_s;
    logic [BEAT_W-1:0]  beat_inc_s;
    close_reason_e      new_reason_s;
    logic               xfer_s;
    close_reason_e      xfer_reason_s;
    logic               xfer_last_s;
    logic [PAYLOAD_W-1:0] o_payload_in_s;
    logic [PAYLOAD_W-1:0] o_payload_s;

    // A held beat carries its close reason; anything other than NONE stalls input.
    assign h_close_s     = (h_reason_q != CLOSE_NONE);
    assign axis_i_tready = n_reset && (!h_valid_q || (!h_close_s && o_free_s));
    assign accept_s      = axis_i_tvalid && axis_i_tready;
    assign idle_hit_s    = (idle_cnt_q == IDLE_LAST_C);
    assign beat_inc_s    = beat_cnt_q + {{(BEAT_W-1){1'b0}}, 1'b1};
    assign xfer_last_s   = (xfer_reason_s != CLOSE_NONE);

    // Close reason for an incoming beat; upstream tlast outranks the length limit.
    always_comb begin
        new_reason_s = CLOSE_NONE;
        if (axis_i_tlast) begin
            new_reason_s = CLOSE_TLAST;
        end else if (beat_inc_s == MAX_LEN_C) begin
            new_reason_s = CLOSE_MAXLEN;
        end else begin
            new_reason_s = CLOSE_NONE;
        end
    end

    // H->O transfer decode: closed beat first, then push-out by a new beat, then timeout.
    always_comb begin
        xfer_s        = 1'b0;
        xfer_reason_s = CLOSE_NONE;
        if (h_valid_q && o_free_s) begin
            if (h_close_s) begin
                xfer_s        = 1'b1;
                xfer_reason_s = h_reason_q;
            end else if (accept_s) begin
                xfer_s        = 1'b1;
                xfer_reason_s = CLOSE_NONE;
            end else if (idle_hit_s) begin
                xfer_s        = 1'b1;
                xfer_reason_s = CLOSE_TIMEOUT;
            end else begin
                xfer_s        = 1'b0;
            end
        end else begin
            xfer_s = 1'b0;
        end
    end

    // Next-state for H and the counters; idle_cnt saturates so a blocked timeout fires once O frees.
    always_comb begin
        h_valid_d  = h_valid_q;
        h_data_d   = h_data_q;
        h_reason_d = h_reason_q;
        beat_cnt_d = beat_cnt_q;
        idle_cnt_d = idle_cnt_q;
        if (accept_s) begin
            h_valid_d  = 1'b1;
            h_data_d   = axis_i_tdata;
            h_reason_d = new_reason_s;
            beat_cnt_d = beat_inc_s;
            idle_cnt_d = {IDLE_W{1'b0}};
        end else if (xfer_s) begin
            h_valid_d  = 1'b0;
            h_reason_d = CLOSE_NONE;
            beat_cnt_d = {BEAT_W{1'b0}};
            idle_cnt_d = {IDLE_W{1'b0}};
        end else if (h_valid_q && !h_close_s && !idle_hit_s) begin
            idle_cnt_d = idle_cnt_q + {{(IDLE_W-1){1'b0}}, 1'b1};
        end else begin
            idle_cnt_d = idle_cnt_q;
        end
    end

    // State registers for H and the counters.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            h_valid_q  <= 1'b0;
            h_data_q   <= {DATA_W{1'b0}};
            h_reason_q <= CLOSE_NONE;
            beat_cnt_q <= {BEAT_W{1'b0}};
            idle_cnt_q <= {IDLE_W{1'b0}};
        end else begin
            h_valid_q  <= h_valid_d;
            h_data_q   <= h_data_d;
            h_reason_q <= h_reason_d;
            beat_cnt_q <= beat_cnt_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

`ifdef AXIS_PACKETISER_TUSER_EN
    assign o_payload_in_s = {(xfer_reason_s == CLOSE_TIMEOUT), h_data_q};
    assign axis_o_tuser   = o_payload_s[DATA_W];
    assign axis_o_tdata   = o_payload_s[DATA_W-1:0];
`else
    assign o_payload_in_s = h_data_q;
    assign axis_o_tdata   = o_payload_s;
`endif

    axis_out_reg #(
        .PAYLOAD_W (PAYLOAD_W)
    ) u_out_reg (
        .clk_i     (clk),
        .rst_ni    (n_reset),
        .load_i    (xfer_s),
        .payload_i (o_payload_in_s),
        .last_i    (xfer_last_s),
        .ready_i   (axis_o_tready),
        .free_o    (o_free_s),
        .valid_o   (axis_o_tvalid),
        .last_o    (axis_o_tlast),
        .payload_o (o_payload_s)
    );

endmodule

// File: tb/tb_axis_packetiser.sv
// -----------------------------------------------------------------------------
// tb_axis_packetiser
// Two packetiser instances: A (MAX_LEN=4, TIMEOUT=16) for directed cases and
// B (MAX_LEN=7, TIMEOUT=5) for the timeout case and the long random run.
// The reference model works on whole beats: each beat carries its data, its
// upstream tlast and the idle gap that follows it. A short gap (< TIMEOUT)
// never lets a timeout fire; a long gap (>= TIMEOUT+3, with ready forced high
// on its last 3 cycles) always does. Expected last = tlast, or the MAX_LEN-th
// beat since the previous last, or a long gap after a non-closing beat.
// -----------------------------------------------------------------------------
module tb_axis_packetiser;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       n_rst    [2];
    logic       i_tready [2];
    logic       i_tvalid [2];
    logic       i_tlast  [2];
    logic [7:0] i_tdata  [2];
    logic       o_tready [2];
    logic       o_tvalid [2];
    logic       o_tlast  [2];
    logic [7:0] o_tdata  [2];
`ifdef AXIS_PACKETISER_TUSER_EN
    logic       o_tuser  [2];
`endif

    axis_packetiser #(.AXIS_BYTES(1), .MAX_LEN(4), .TIMEOUT(16)) u_dut_a (
        .clk           (clk),
        .n_reset       (n_rst[0]),
        .axis_i_tready (i_tready[0]),
        .axis_i_tvalid (i_tvalid[0]),
        .axis_i_tlast  (i_tlast[0]),
        .axis_i_tdata  (i_tdata[0]),
        .axis_o_tready (o_tready[0]),
        .axis_o_tvalid (o_tvalid[0]),
        .axis_o_tlast  (o_tlast[0]),
`ifdef AXIS_PACKETISER_TUSER_EN
        .axis_o_tuser  (o_tuser[0]),
`endif
        .axis_o_tdata  (o_tdata[0])
    );

    axis_packetiser #(.AXIS_BYTES(1), .MAX_LEN(7), .TIMEOUT(5)) u_dut_b (
        .clk           (clk),
        .n_reset       (n_rst[1]),
        .axis_i_tready (i_tready[1]),
        .axis_i_tvalid (i_tvalid[1]),
        .axis_i_tlast  (i_tlast[1]),
        .axis_i_tdata  (i_tdata[1]),
        .axis_o_tready (o_tready[1]),
        .axis_o_tvalid (o_tvalid[1]),
        .axis_o_tlast  (o_tlast[1]),
`ifdef AXIS_PACKETISER_TUSER_EN
        .axis_o_tuser  (o_tuser[1]),
`endif
        .axis_o_tdata  (o_tdata[1])
    );

    typedef struct {
        logic [7:0] data;
        bit         tlast;
        int         gap;
        bit         lng;
    } beat_t;

    typedef struct {
        logic [7:0] data;
        bit         last;
        bit         user;
        int         idx;
    } exp_t;

    beat_t      bq [$];
    exp_t       eq [$];
    int         acc_at [int];
    int         lat_of [int];
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         sel = 0;
    int         out_pos = 0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;

    function automatic int ml_of(input int s);
        return (s == 0) ? 4 : 7;
    endfunction

    function automatic int to_of(input int s);
        return (s == 0) ? 16 : 5;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic add_beat(input logic [7:0] d, input bit tl, input int g, input bit lng);
        beat_t b;
        b.data = d; b.tlast = tl; b.gap = g; b.lng = lng;
        bq.push_back(b);
    endtask

    // Expected output stream for the beats queued in bq.
    task automatic build_expected(input int s);
        int   pos;
        bit   forced;
        exp_t e;
        pos = 0;
        for (int i = 0; i < bq.size(); i++) begin
            pos++;
            forced = bq[i].tlast || (pos == ml_of(s));
            e.data = bq[i].data;
            e.last = forced || bq[i].lng;
            e.user = bq[i].lng && !forced;
            e.idx  = i;
            if (e.last) pos = 0;
            eq.push_back(e);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        check_val("beat_expected", 32'(eq.size() > 0), 32'd1);
        if (eq.size() > 0) begin
            e = eq.pop_front();
            check_val("out_data", 32'(o_tdata[sel]), 32'(e.data));
            check_val("out_last", 32'(o_tlast[sel]), 32'(e.last));
`ifdef AXIS_PACKETISER_TUSER_EN
            check_val("out_tuser", 32'(o_tuser[sel]), 32'(e.user));
`endif
            lat_of[e.idx] = cyc - acc_at[e.idx] - 1;
            out_pos++;
            check_val("pkt_len_ok", 32'(out_pos <= ml_of(sel)), 32'd1);
            if (o_tlast[sel]) out_pos = 0;
        end
    endtask

    // One clock: inputs are already set (at negedge); sample, then cross the posedge.
    task automatic step(output bit acc);
        #1;
        if (prev_stall) begin
            check_val("stall_data", 32'(o_tdata[sel]), 32'(prev_data));
            check_val("stall_last", 32'(o_tlast[sel]), 32'(prev_last));
        end
        prev_stall = o_tvalid[sel] && !o_tready[sel];
        prev_data  = o_tdata[sel];
        prev_last  = o_tlast[sel];
        if (o_tvalid[sel] && o_tready[sel]) pop_check();
        acc = i_tvalid[sel] && i_tready[sel];
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // Drive the queued beats; rmode 0 = ready high, 1 = random ready. [st_lo,st_hi) forces ready low.
    task automatic run_beats(input int s, input int rmode, input int st_lo, input int st_hi,
                             output int n_stall_acc);
        int bi, gap_left, t0, rel, c, budget;
        bit long_cur, acc, r;
        sel = s; prev_stall = 1'b0; out_pos = 0;
        acc_at.delete(); lat_of.delete();
        build_expected(s);
        bi = 0; gap_left = 0; long_cur = 1'b0; n_stall_acc = 0;
        t0 = cyc; budget = 40 * bq.size() + 400;
        while ((bi < bq.size() || gap_left > 0 || eq.size() > 0) && (cyc - t0) < budget) begin
            rel = cyc - t0;
            if (gap_left > 0 || bi >= bq.size()) begin
                i_tvalid[s] = 1'b0; i_tlast[s] = 1'b0;
            end else begin
                i_tvalid[s] = 1'b1; i_tlast[s] = bq[bi].tlast; i_tdata[s] = bq[bi].data;
            end
            r = (rmode == 0) ? 1'b1 : ($urandom_range(0, 99) < 70);
            if (long_cur && gap_left > 0 && gap_left <= 3) r = 1'b1;
            if (rel >= st_lo && rel < st_hi) r = 1'b0;
            o_tready[s] = r;
            c = cyc;
            step(acc);
            if (acc && rel >= st_lo && rel < st_hi) n_stall_acc++;
            if (gap_left > 0) begin
                gap_left--;
            end else if (acc) begin
                acc_at[bi] = c;
                gap_left   = bq[bi].gap;
                long_cur   = bq[bi].lng;
                bi++;
            end
        end
        check_val("beats_sent", 32'(bi), 32'(bq.size()));
        check_val("drain_left", 32'(eq.size()), 32'd0);
        i_tvalid[s] = 1'b0; i_tlast[s] = 1'b0; o_tready[s] = 1'b1;
        bq.delete(); eq.delete();
    endtask

    initial begin
        int  nst;
        int  g;
        int  rv;
        bit  lng;
        for (int s = 0; s < 2; s++) begin
            n_rst[s] = 1'b0; i_tvalid[s] = 1'b0; i_tlast[s] = 1'b0;
            i_tdata[s] = 8'd0; o_tready[s] = 1'b1;
        end
        i_tvalid[0] = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            check_val("rst_tvalid", 32'(o_tvalid[s]), 32'd0);
            check_val("rst_tlast",  32'(o_tlast[s]),  32'd0);
            check_val("rst_tdata",  32'(o_tdata[s]),  32'd0);
            check_val("rst_tready", 32'(i_tready[s]), 32'd0);
        end
        i_tvalid[0] = 1'b0;
        @(negedge clk);
        n_rst[0] = 1'b1; n_rst[1] = 1'b1;
        @(negedge clk);

        // MAX_LEN boundary on a continuous stream, tail flushed by timeout
        for (int i = 0; i < 10; i++) add_beat(8'(i), 1'b0, (i == 9) ? 20 : 0, i == 9);
        run_beats(0, 0, -1, -1, nst);
        check_val("maxlen_lat", 32'(lat_of[3]), 32'd1);
        check_val("timeout_lat16", 32'(lat_of[9]), 32'd16);

        // Upstream tlast, then beat counting restarts from zero
        add_beat(8'hC0, 1'b0, 0, 1'b0);
        add_beat(8'hC1, 1'b0, 0, 1'b0);
        add_beat(8'hC2, 1'b1, 0, 1'b0);
        for (int i = 0; i < 4; i++) add_beat(8'hD0 + 8'(i), 1'b0, (i == 3) ? 20 : 0, i == 3);
        run_beats(0, 0, -1, -1, nst);
        check_val("tlast_lat", 32'(lat_of[2]), 32'd1);

        // Downstream stall for 20 cycles mid-stream
        for (int i = 0; i < 12; i++) add_beat(8'h40 + 8'(i), 1'b0, (i == 11) ? 20 : 0, i == 11);
        run_beats(0, 0, 3, 23, nst);
        check_val("stall_accepts_le2", 32'(nst <= 2), 32'd1);

        // Reset with H and O both occupied
        o_tready[0] = 1'b0; i_tvalid[0] = 1'b1; i_tlast[0] = 1'b0; i_tdata[0] = 8'h11;
        @(negedge clk);
        i_tdata[0] = 8'h22;
        @(negedge clk);
        i_tvalid[0] = 1'b0;
        #1;
        check_val("pre_rst_tvalid", 32'(o_tvalid[0]), 32'd1);
        check_val("pre_rst_tdata",  32'(o_tdata[0]),  32'h11);
        check_val("pre_rst_tready", 32'(i_tready[0]), 32'd0);
        #1;
        n_rst[0] = 1'b0;
        #1;
        check_val("mid_rst_tvalid", 32'(o_tvalid[0]), 32'd0);
        check_val("mid_rst_tlast",  32'(o_tlast[0]),  32'd0);
        check_val("mid_rst_tdata",  32'(o_tdata[0]),  32'd0);
        check_val("mid_rst_tready", 32'(i_tready[0]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        n_rst[0] = 1'b1; o_tready[0] = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) add_beat(8'hE0 + 8'(i), 1'b0, (i == 4) ? 20 : 0, i == 4);
        run_beats(0, 0, -1, -1, nst);

        // Single beat forced out by timeout on instance B
        add_beat(8'hA5, 1'b0, 8, 1'b1);
        run_beats(1, 0, -1, -1, nst);
        check_val("timeout_lat5", 32'(lat_of[0]), 32'd5);

        // Long random run on instance B
        for (int i = 0; i < 10000; i++) begin
            rv = int'($urandom_range(0, 99));
            if (rv < 5 || i == 9999) begin
                g = int'($urandom_range(8, 13)); lng = 1'b1;
            end else if (rv < 60) begin
                g = 0; lng = 1'b0;
            end else begin
                g = int'($urandom_range(1, 4)); lng = 1'b0;
            end
            add_beat(8'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0), g, lng);
        end
        run_beats(1, 1, -1, -1, nst);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
